// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_arbiter
// Purpose  : Round-robin arbiter sharing one APB slave port among requesters.
// Revision : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
  parameter int NB_REQ         = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NB_REQ-1:0]                req_i,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NB_REQ-1:0]                req_we_i,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic [NB_REQ-1:0]                req_gnt_o,
  output logic [NB_REQ-1:0]                rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0]        rsp_rdata_o,
  output logic                             rsp_err_o,
  output logic                             busy_o,
  output logic [APB_ADDR_WIDTH-1:0]        paddr_o,
  output logic [APB_DATA_WIDTH-1:0]        pwdata_o,
  output logic                             pwrite_o,
  output logic                             psel_o,
  output logic                             penable_o,
  input  logic [APB_DATA_WIDTH-1:0]        prdata_i,
  input  logic                             pready_i,
  input  logic                             pslverr_i
);

  localparam int c_IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int c_TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit                c_TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TIMEOUT_CYCLES);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NB_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [APB_ADDR_WIDTH-1:0] w_addr_arr  [NB_REQ];
  logic [APB_DATA_WIDTH-1:0] w_wdata_arr [NB_REQ];

  logic [c_IDX_W-1:0]        r_ptr;
  logic [c_IDX_W-1:0]        r_idx;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic                      r_we;
  logic [c_TO_W-1:0]         r_to_cnt;
  logic [NB_REQ-1:0]         r_rsp_valid;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_err;

  logic                      w_win_found;
  logic [c_IDX_W-1:0]        w_win_idx;
  int                        w_cand;
  logic [NB_REQ-1:0]         w_gnt;
  logic                      w_accept;
  logic                      w_done;
  logic                      w_timeout;

  generate
    for (genvar k = 0; k < NB_REQ; k++) begin : g_unpack
      assign w_addr_arr[k]  = req_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
      assign w_wdata_arr[k] = req_wdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end
  endgenerate

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = 0;
    for (int off = 0; off < NB_REQ; off++) begin
      w_cand = int'(r_ptr) + off;
      if (w_cand >= NB_REQ) w_cand = w_cand - NB_REQ;
      if (!w_win_found && req_i[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = c_IDX_W'(w_cand);
      end
    end
  end

  assign w_accept  = (r_state == ST_IDLE) && w_win_found;
  assign w_done    = (r_state == ST_ACCESS) && pready_i;
  assign w_timeout = c_TO_EN && (r_state == ST_ACCESS) && !pready_i && (r_to_cnt == c_TO_LIMIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    busy_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_found) begin
          w_gnt[w_win_idx] = 1'b1;
          w_state_nxt      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        psel_o      = 1'b1;
        busy_o      = 1'b1;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        busy_o    = 1'b1;
        if (w_done || w_timeout) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr       <= '0;
      r_idx       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_to_cnt    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      if (w_accept) begin
        r_idx   <= w_win_idx;
        r_addr  <= w_addr_arr[w_win_idx];
        r_wdata <= w_wdata_arr[w_win_idx];
        r_we    <= req_we_i[w_win_idx];
        r_ptr   <= (w_win_idx == c_IDX_LAST) ? '0 : w_win_idx + 1'b1;
      end
      // Counts wait cycles seen so far in ACCESS; saturates at all-ones.
      if (r_state == ST_SETUP) begin
        r_to_cnt <= '0;
      end else if (r_state == ST_ACCESS && !pready_i && r_to_cnt != '1) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_done) begin
        r_rsp_valid[r_idx] <= 1'b1;
        r_rsp_rdata        <= r_we ? '0 : prdata_i;
        r_rsp_err          <= pslverr_i;
      end else if (w_timeout) begin
        r_rsp_valid[r_idx] <= 1'b1;
        r_rsp_err          <= 1'b1;
      end
    end
  end

  assign req_gnt_o   = w_gnt;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign paddr_o     = r_addr;
  assign pwdata_o    = r_wdata;
  assign pwrite_o    = r_we;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_req_arbiter
// Purpose  : Directed self-checking bench for apb_req_arbiter (3 requesters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;
  localparam int NB = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NB-1:0]   req, req_we;
  logic [NB*AW-1:0] req_addr;
  logic [NB*DW-1:0] req_wdata;
  logic [NB-1:0]   gnt, rsp_valid;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic [AW-1:0]   paddr;
  logic            rsp_err, busy, pwrite, psel, penable, pready, pslverr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  apb_req_arbiter #(
    .NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .req_addr_i(req_addr), .req_we_i(req_we), .req_wdata_i(req_wdata),
    .req_gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .busy_o(busy), .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite),
    .psel_o(psel), .penable_o(penable),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset defaults
    repeat (3) cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc(); #1;
      check("rst_busy", busy, 0);
    end
    check("rst_gnt", gnt, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_ctl", {pwrite, psel, penable}, 0);

    // Single zero-wait write from requester 0
    cyc();
    req = 3'b001; req_we = 3'b001; pready = 1'b1;
    req_addr[0 +: AW] = 32'h1A10_2000; req_wdata[0 +: DW] = 32'hDEAD_BEEF;
    #1;
    check("wr_gnt", gnt, 3'b001);
    check("wr_c0_psel", psel, 0);
    cyc(); req = '0; #1;
    check("wr_c1_ctl", {psel, penable, pwrite, busy}, 4'b1011);
    check("wr_c1_paddr", paddr, 32'h1A10_2000);
    check("wr_c1_pwdata", pwdata, 32'hDEAD_BEEF);
    check("wr_c1_gnt", gnt, 0);
    cyc(); #1;
    check("wr_c2_ctl", {psel, penable}, 2'b11);
    check("wr_c2_paddr", paddr, 32'h1A10_2000);
    check("wr_c2_pwdata", pwdata, 32'hDEAD_BEEF);
    cyc(); #1;
    check("wr_c3_valid", rsp_valid, 3'b001);
    check("wr_c3_err", rsp_err, 0);
    check("wr_c3_ctl", {psel, busy}, 2'b00);

    // Round-robin with all requesters held high
    do_reset();
    req_we = '0;
    for (int k = 0; k < NB; k++) req_addr[k*AW +: AW] = 32'h4000_0000 + 32'(k * 16);
    for (int c = 0; c < 18; c++) begin
      cyc();
      req = 3'b111; prdata = 32'h100 + 32'(c);
      #1;
      if (c % 3 == 0) check("rr_gnt", gnt, 3'b001 << ((c / 3) % 3));
      else            check("rr_gnt_idle", gnt, 0);
      if (c % 3 == 1) check("rr_paddr", paddr, 32'h4000_0000 + 32'(16 * ((c / 3) % 3)));
      if (c % 3 == 0 && c >= 3) begin
        check("rr_valid", rsp_valid, 3'b001 << ((c / 3 - 1) % 3));
        check("rr_rdata", rsp_rdata, 32'h100 + 32'(c - 1));
      end
    end
    cyc(); req = '0; #1;
    check("rr_last_valid", rsp_valid, 3'b100);
    check("rr_last_rdata", rsp_rdata, 32'h100 + 32'd17);
    check("rr_last_gnt", gnt, 0);

    // Read with four wait states and a slave error
    cyc();
    req = 3'b010; req_we = '0; req_addr[AW +: AW] = 32'h2000_0010;
    pready = 1'b0; prdata = 32'hFFFF_FFFF; pslverr = 1'b1;
    #1;
    check("ws_gnt", gnt, 3'b010);
    cyc(); req = '0; #1;
    for (int c = 2; c <= 5; c++) begin
      cyc(); #1;
      check("ws_access", {psel, penable}, 2'b11);
      check("ws_no_valid", rsp_valid, 0);
    end
    cyc(); pready = 1'b1; prdata = 32'h55AA_1234; pslverr = 1'b1; #1;
    cyc(); pready = 1'b0; prdata = '0; pslverr = 1'b0; #1;
    check("ws_valid", rsp_valid, 3'b010);
    check("ws_rdata", rsp_rdata, 32'h55AA_1234);
    check("ws_err", rsp_err, 1);
    check("ws_busy", busy, 0);

    // Timeout on requester 2 while requester 0 waits
    cyc();
    req = 3'b101; req_we = 3'b001;
    req_addr[2*AW +: AW] = 32'h3000_0020; req_addr[0 +: AW] = 32'h3000_0000;
    req_wdata[0 +: DW] = 32'h1234_5678; prdata = 32'hCAFE_F00D; pready = 1'b0;
    #1;
    check("to_gnt", gnt, 3'b100);
    cyc(); #1;
    for (int c = 2; c <= 10; c++) begin
      cyc(); #1;
      check("to_access", {psel, penable}, 2'b11);
      check("to_no_valid", rsp_valid, 0);
    end
    cyc(); #1;
    check("to_valid", rsp_valid, 3'b100);
    check("to_err", rsp_err, 1);
    check("to_rdata", rsp_rdata, 0);
    check("to_next_gnt", gnt, 3'b001);
    check("to_psel", psel, 0);
    cyc(); req = '0; pready = 1'b1; #1;
    check("to_wr_paddr", paddr, 32'h3000_0000);
    check("to_wr_pwdata", {pwrite, pwdata}, {1'b1, 32'h1234_5678});
    cyc(); #1;
    cyc(); #1;
    check("to_wr_valid", rsp_valid, 3'b001);
    check("to_wr_err", rsp_err, 0);
    check("to_wr_rdata", rsp_rdata, 0);

    // Asynchronous reset in the middle of ACCESS
    cyc();
    req = 3'b010; req_we = '0; req_addr[AW +: AW] = 32'h5000_0000; pready = 1'b0;
    #1;
    check("mr_gnt", gnt, 3'b010);
    cyc(); req = '0; #1;
    cyc(); #1;
    check("mr_access", {psel, penable}, 2'b11);
    cyc(); #1;
    rst_n = 1'b0;
    #1;
    check("mr_async_ctl", {psel, penable, busy}, 3'b000);
    check("mr_paddr", paddr, 0);
    for (int c = 0; c < 3; c++) begin
      cyc(); #1;
      check("mr_no_valid", rsp_valid, 0);
    end
    cyc();
    rst_n = 1'b1; req = 3'b011; pready = 1'b1;
    #1;
    check("mr_first_gnt", gnt, 3'b001);
    cyc(); req = '0; #1;
    cyc(); #1;
    cyc(); #1;
    check("mr_valid", rsp_valid, 3'b001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
